// File: rtl/l2_msg_pkg.sv
// Shared definitions for the L2 msg2 egress path: response type codes,
// NoC header field layout, type classification helpers and FSM states.
package l2_msg_pkg;

  // Response message type codes
  localparam logic [7:0] MSG_INV_ACK   = 8'h11;
  localparam logic [7:0] MSG_WB_ACK    = 8'h12;
  localparam logic [7:0] MSG_DATA_SHR  = 8'h13;
  localparam logic [7:0] MSG_DATA_EXC  = 8'h14;
  localparam logic [7:0] MSG_NACK      = 8'h1d;

  // Header flit layout (LSB positions and widths)
  localparam int unsigned HDR_DEST_LSB = 58;
  localparam int unsigned HDR_DEST_W   = 6;
  localparam int unsigned HDR_TYPE_LSB = 50;
  localparam int unsigned HDR_TYPE_W   = 8;
  localparam int unsigned HDR_TAG_LSB  = 24;
  localparam int unsigned HDR_TAG_W    = 26;
  localparam int unsigned HDR_LEN_LSB  = 20;
  localparam int unsigned HDR_LEN_W    = 4;

  // Types that are followed by one data flit
  function automatic logic msg_has_data(input logic [7:0] t);
    return (t == MSG_DATA_SHR) || (t == MSG_DATA_EXC);
  endfunction

  // Types in the recognised set; anything else is sent header-only and flagged
  function automatic logic msg_known(input logic [7:0] t);
    return (t == MSG_INV_ACK) || (t == MSG_WB_ACK) || (t == MSG_NACK) ||
           (t == MSG_DATA_SHR) || (t == MSG_DATA_EXC);
  endfunction

  typedef enum logic [1:0] {
    EG_IDLE,
    EG_HDR,
    EG_DATA
  } egress_state_e;

endpackage

// File: rtl/l2_sync_fifo.sv
// Synchronous FIFO with registered occupancy count. The head entry is
// presented combinationally from storage so consumers can read it in place.
module l2_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Entry storage; written on accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally (power-of-2 depth); count tracks push/pop balance
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/l2_msg2_egress.sv
// L2 msg2 egress: buffers response messages and serialises each one into a
// header flit plus an optional data flit toward the NoC.
module l2_msg2_egress
  import l2_msg_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TYPE_W = 8,
  parameter int unsigned SRC_W  = 6,
  parameter int unsigned TAG_W  = 26,
  parameter int unsigned DATA_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    msg2_valid,
  output logic                    msg2_ready,
  input  logic [TYPE_W-1:0]       msg2_type,
  input  logic [SRC_W-1:0]        msg2_dest,
  input  logic [TAG_W-1:0]        msg2_tag,
  input  logic [DATA_W-1:0]       msg2_data,
  output logic                    noc_valid,
  input  logic                    noc_ready,
  output logic [DATA_W-1:0]       noc_flit,
  output logic                    noc_last,
  output logic [$clog2(DEPTH):0]  msg_count,
  output logic                    err_bad_type
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = TYPE_W + SRC_W + TAG_W + DATA_W;

  egress_state_e     state_q;
  logic              noc_valid_q;
  logic              push, pop, more;
  logic              fifo_full, fifo_empty;
  logic [ENT_W-1:0]  head;
  logic [TYPE_W-1:0] head_type;
  logic [SRC_W-1:0]  head_dest;
  logic [TAG_W-1:0]  head_tag;
  logic [DATA_W-1:0] head_data;
  logic              head_has_data;
  logic [DATA_W-1:0] hdr_flit;

  assign msg2_ready   = !fifo_full;
  assign push         = msg2_valid && msg2_ready;
  assign err_bad_type = push && !msg_known(msg2_type);

  l2_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({msg2_type, msg2_dest, msg2_tag, msg2_data}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (msg_count)
  );

  assign {head_type, head_dest, head_tag, head_data} = head;
  assign head_has_data = msg_has_data(head_type);

  // Another message will be at the head after this pop: one still queued
  // behind it, or one arriving this same cycle.
  assign more = (msg_count > CNT_W'(1)) || push;

  assign pop = noc_valid_q && noc_ready &&
               ((state_q == EG_DATA) || ((state_q == EG_HDR) && !head_has_data));

  // Header flit assembled from the FIFO head entry
  always_comb begin
    hdr_flit = '0;
    hdr_flit[HDR_DEST_LSB +: SRC_W]     = head_dest;
    hdr_flit[HDR_TYPE_LSB +: TYPE_W]    = head_type;
    hdr_flit[HDR_TAG_LSB  +: TAG_W]     = head_tag;
    hdr_flit[HDR_LEN_LSB  +: HDR_LEN_W] = HDR_LEN_W'(head_has_data);
  end

  // Flit outputs follow registered state and the (stable until popped) head entry
  always_comb begin
    noc_flit = '0;
    noc_last = 1'b0;
    if (noc_valid_q) begin
      noc_flit = (state_q == EG_DATA) ? head_data : hdr_flit;
      noc_last = (state_q == EG_DATA) || !head_has_data;
    end
  end

  assign noc_valid = noc_valid_q;

  // Serializer FSM; leaving IDLE on an incoming push gives header-next-cycle latency
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EG_IDLE;
      noc_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EG_IDLE: begin
          if (!fifo_empty || push) begin
            state_q     <= EG_HDR;
            noc_valid_q <= 1'b1;
          end
        end
        EG_HDR: begin
          if (noc_ready) begin
            if (head_has_data) begin
              state_q <= EG_DATA;
            end else if (!more) begin
              state_q     <= EG_IDLE;
              noc_valid_q <= 1'b0;
            end
          end
        end
        EG_DATA: begin
          if (noc_ready) begin
            if (more) begin
              state_q <= EG_HDR;
            end else begin
              state_q     <= EG_IDLE;
              noc_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= EG_IDLE;
          noc_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
